// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - Execute stage: accumulator, ALU, iterative multiplier, EX/MEM register
// The multiplier runs one shift-add step per cycle and holds stall high until the last step.
module ex_stage #(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [2:0]       alu_op,
  input  logic             ac_we,
  input  logic [WIDTH-1:0] RegVal_in,
  input  logic [WIDTH-1:0] PC_in,
  input  logic             Wr_in,
  input  logic             Wm_in,
  input  logic             Rm_in,
  input  logic             Neq_in,
  input  logic             J_in,
  input  logic             JC_in,
  output logic             stall,
  output logic             valid_out,
  output logic [WIDTH-1:0] acOutValue,
  output logic             zeroOut,
  output logic [WIDTH-1:0] RegVal,
  output logic [WIDTH-1:0] PC,
  output logic             Wr,
  output logic             Wm,
  output logic             Rm,
  output logic             Neq,
  output logic             J,
  output logic             JC
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] ac;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] sh_pc;
  logic             sh_ac_we;
  logic [5:0]       sh_ctrl;
  logic [5:0]       ctrl;
  logic [5:0]       ctrl_in;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] next_product;

  assign ctrl_in = {Wr_in, Wm_in, Rm_in, Neq_in, J_in, JC_in};
  assign {Wr, Wm, Rm, Neq, J, JC} = ctrl;
  assign stall = (state == MUL);

  always_comb begin
    result = ac;
    case (alu_op)
      OP_NOP:  result = ac;
      OP_ADD:  result = ac + RegVal_in;
      OP_SUB:  result = ac - RegVal_in;
      OP_AND:  result = ac & RegVal_in;
      OP_OR:   result = ac | RegVal_in;
      OP_LDI:  result = RegVal_in;
      OP_SHL:  result = {ac[WIDTH-2:0], 1'b0};
      default: result = ac;
    endcase
  end

  always_comb begin
    next_product = product;
    if (mplier[count]) next_product = product + (mcand << count);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      ac         <= '0;
      mcand      <= '0;
      mplier     <= '0;
      product    <= '0;
      sh_pc      <= '0;
      sh_ac_we   <= 1'b0;
      sh_ctrl    <= '0;
      valid_out  <= 1'b0;
      acOutValue <= '0;
      zeroOut    <= 1'b0;
      RegVal     <= '0;
      PC         <= '0;
      ctrl       <= '0;
    end else if (flush) begin
      state     <= IDLE;
      count     <= '0;
      valid_out <= 1'b0;
      ctrl      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in && alu_op == OP_MUL) begin
            state     <= MUL;
            count     <= '0;
            mcand     <= ac;
            mplier    <= RegVal_in;
            product   <= '0;
            sh_pc     <= PC_in;
            sh_ac_we  <= ac_we;
            sh_ctrl   <= ctrl_in;
            valid_out <= 1'b0;
            ctrl      <= '0;
          end else if (valid_in) begin
            valid_out  <= 1'b1;
            acOutValue <= result;
            zeroOut    <= (result == '0);
            RegVal     <= RegVal_in;
            PC         <= PC_in;
            ctrl       <= ctrl_in;
            if (ac_we) ac <= result;
          end else begin
            valid_out <= 1'b0;
            ctrl      <= '0;
          end
        end
        MUL: begin
          product <= next_product;
          count   <= count + 1'b1;
          if (count == LAST) begin
            state      <= IDLE;
            valid_out  <= 1'b1;
            acOutValue <= next_product;
            zeroOut    <= (next_product == '0);
            RegVal     <= mplier;
            PC         <= sh_pc;
            ctrl       <= sh_ctrl;
            if (sh_ac_we) ac <= next_product;
          end else begin
            valid_out <= 1'b0;
            ctrl      <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - Directed self-checking bench for ex_stage
// The accumulator is observed by issuing a NOP, whose result is AC.
module tb_ex_stage;

  logic       clock = 1'b0;
  logic       reset, flush, valid_in, ac_we;
  logic [2:0] alu_op;
  logic [7:0] RegVal_in, PC_in;
  logic       Wr_in, Wm_in, Rm_in, Neq_in, J_in, JC_in;
  logic       stall, valid_out, zeroOut;
  logic [7:0] acOutValue, RegVal, PC;
  logic       Wr, Wm, Rm, Neq, J, JC;

  int vectors = 0;
  int miscompares = 0;

  ex_stage #(.WIDTH(8), .MUL_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .flush(flush), .valid_in(valid_in),
    .alu_op(alu_op), .ac_we(ac_we), .RegVal_in(RegVal_in), .PC_in(PC_in),
    .Wr_in(Wr_in), .Wm_in(Wm_in), .Rm_in(Rm_in), .Neq_in(Neq_in),
    .J_in(J_in), .JC_in(JC_in), .stall(stall), .valid_out(valid_out),
    .acOutValue(acOutValue), .zeroOut(zeroOut), .RegVal(RegVal), .PC(PC),
    .Wr(Wr), .Wm(Wm), .Rm(Rm), .Neq(Neq), .J(J), .JC(JC)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] rv, input logic we);
    valid_in  = 1'b1;
    alu_op    = op;
    RegVal_in = rv;
    ac_we     = we;
  endtask

  task automatic check_ac(input string tag, input logic [7:0] exp);
    issue(3'b000, 8'h00, 1'b0);
    tick();
    chk(tag, {8'h00, acOutValue}, {8'h00, exp});
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; valid_in = 1'b1; alu_op = 3'b001; ac_we = 1'b1;
    RegVal_in = 8'h55; PC_in = 8'h11;
    {Wr_in, Wm_in, Rm_in, Neq_in, J_in, JC_in} = 6'b111111;
    tick(); tick();
    chk("reset_valid_out", {15'h0, valid_out}, 16'h0);
    chk("reset_outputs", {acOutValue, RegVal}, 16'h0000);
    chk("reset_pc_zero", {7'h0, PC, zeroOut}, 16'h0);
    chk("reset_ctrl", {10'h0, Wr, Wm, Rm, Neq, J, JC}, 16'h0);
    chk("reset_stall", {15'h0, stall}, 16'h0);
    reset = 1'b0;
    valid_in = 1'b0;
    {Wr_in, Wm_in, Rm_in, Neq_in, J_in, JC_in} = 6'b000000;
    PC_in = 8'h00;
    check_ac("reset_ac", 8'h00);

    // LDI / ADD wrap / SUB to zero
    issue(3'b101, 8'h07, 1'b1); tick();
    chk("ldi_result", {7'h0, acOutValue, zeroOut}, {7'h0, 8'h07, 1'b0});
    issue(3'b001, 8'hFC, 1'b1); tick();
    chk("add_wrap", {7'h0, acOutValue, zeroOut}, {7'h0, 8'h03, 1'b0});
    issue(3'b010, 8'h03, 1'b1); tick();
    chk("sub_zero", {7'h0, acOutValue, zeroOut}, {7'h0, 8'h00, 1'b1});

    // LDI with controls and PC passthrough
    issue(3'b101, 8'h10, 1'b1); Wm_in = 1'b1; PC_in = 8'h05; tick();
    chk("ldi_ac", {8'h00, acOutValue}, 16'h0010);
    chk("ldi_regval", {8'h00, RegVal}, 16'h0010);
    chk("ldi_pc", {8'h00, PC}, 16'h0005);
    chk("ldi_ctrl_valid", {9'h0, valid_out, Wr, Wm, Rm, Neq, J, JC}, 16'b0000000_0_1_010000);
    Wm_in = 1'b0; PC_in = 8'h00;

    // Bubble clears controls
    valid_in = 1'b0; Wm_in = 1'b1; tick();
    chk("bubble", {9'h0, valid_out, Wr, Wm, Rm, Neq, J, JC}, 16'h0);
    Wm_in = 1'b0;

    // Logic ops: AND without AC write, OR, SHL, SHL dropping the MSB
    issue(3'b101, 8'h05, 1'b1); tick();
    issue(3'b011, 8'h0C, 1'b0); tick();
    chk("and_no_we", {8'h00, acOutValue}, 16'h0004);
    issue(3'b100, 8'h0A, 1'b1); tick();
    chk("or", {8'h00, acOutValue}, 16'h000F);
    issue(3'b111, 8'h00, 1'b1); tick();
    chk("shl", {8'h00, acOutValue}, 16'h001E);
    issue(3'b101, 8'h81, 1'b1); tick();
    issue(3'b111, 8'h00, 1'b1); tick();
    chk("shl_msb", {8'h00, acOutValue}, 16'h0002);

    // MUL 0x0D * 0x0B = 0x8F; inputs changed during stall must be ignored
    issue(3'b101, 8'h0D, 1'b1); tick();
    issue(3'b110, 8'h0B, 1'b1); PC_in = 8'h33; Wr_in = 1'b1; tick();
    issue(3'b001, 8'hFF, 1'b1); PC_in = 8'h99; Wr_in = 1'b0; JC_in = 1'b1;
    begin
      int stall_cycles = 0;
      int bubbles = 0;
      for (int i = 0; i < 20 && stall; i++) begin
        stall_cycles++;
        if (!valid_out) bubbles++;
        tick();
      end
      chk("mul_stall_cycles", 16'(stall_cycles), 16'd8);
      chk("mul_bubbles", 16'(bubbles), 16'd8);
    end
    valid_in = 1'b0; JC_in = 1'b0;
    chk("mul_result", {7'h0, valid_out, acOutValue}, {7'h0, 1'b1, 8'h8F});
    chk("mul_fields", {PC, RegVal}, 16'h330B);
    chk("mul_ctrl_zero", {9'h0, zeroOut, Wr, Wm, Rm, Neq, J, JC}, 16'b0000000_0_0_100000);
    PC_in = 8'h00;
    check_ac("mul_ac", 8'h8F);

    // MUL wrap to zero
    issue(3'b101, 8'h20, 1'b1); tick();
    issue(3'b110, 8'h10, 1'b1); tick();
    valid_in = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("mul_wrap", {6'h0, stall, valid_out, acOutValue}, {6'h0, 1'b0, 1'b1, 8'h00});
    chk("mul_wrap_zero", {15'h0, zeroOut}, 16'h1);

    // Flush on the 4th MUL cycle aborts it
    issue(3'b101, 8'h05, 1'b1); tick();
    issue(3'b110, 8'h03, 1'b1); tick();
    valid_in = 1'b0;
    tick(); tick(); tick();
    chk("pre_flush_stall", {15'h0, stall}, 16'h1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_mul", {14'h0, stall, valid_out}, 16'h0);
    check_ac("flush_mul_ac", 8'h05);

    // Flush on the final MUL iteration wins
    issue(3'b110, 8'h03, 1'b1); tick();
    valid_in = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_last", {14'h0, stall, valid_out}, 16'h0);
    check_ac("flush_last_ac", 8'h05);

    // ADD with flush in the same cycle is dropped
    issue(3'b001, 8'h01, 1'b1); Wr_in = 1'b1; flush = 1'b1; tick();
    flush = 1'b0; Wr_in = 1'b0;
    chk("flush_add", {14'h0, valid_out, Wr}, 16'h0);
    check_ac("flush_add_ac", 8'h05);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
